silife_evolver: RTL and testbench
=================================

SILIFE_EVOLVER -- requirements
Module: silife_evolver

Interface
REQ-001 Parameter ROWS, default 32, number of grid rows; only 32 is supported.
REQ-002 Parameter COLS, default 8, cells per row; only 8 is supported.
REQ-003 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port rst_n  input  1  reset: synchronous and active-low.
REQ-005 Port en  input  1  clock enable; when low, all state holds.
REQ-006 Port wr_en  input  1  load strobe from the pattern source.
REQ-007 Port row_select  input  5  row index for a load.
REQ-008 Port cells  input  8  row data for a load; bit i is column i.
REQ-009 Port step  input  1  request to compute one generation.
REQ-010 Port rd_row  input  5  row index for readout.
REQ-011 Port rd_cells  output  8  combinational readout of grid[rd_row].
REQ-012 Port busy  output  1  high while a generation is being computed.
REQ-013 Port gen_count  output  16  generations completed since reset.
REQ-014 Port wr_drop  output  1  sticky flag: a load was ignored because busy was high.

Function
REQ-015 Storage: 32x8 cell grid in registers; 1 = alive.
REQ-016 Load: when en=1, busy=0 and wr_en=1, grid[row_select] <= cells on that edge.
REQ-017 When en=1, busy=1 and wr_en=1: the grid is unchanged and wr_drop <= 1.
REQ-018 FSM states are IDLE, PREP and COMP; any illegal encoding returns to IDLE.
REQ-019 IDLE->PREP when en=1, step=1 and wr_en=0; if step and wr_en are both high, the load wins and the step is discarded.
REQ-020 PREP (1 cycle) latches first = grid[0] and prev = wrap ? grid[31] : 0, and clears the row counter r to 0.
REQ-021 COMP (32 cycles), per cycle: cur = grid[r]; next = (r==31) ? (wrap ? first : 0) : grid[r+1]; grid[r] <= rule(prev,cur,next); prev <= cur; r <= r+1.
REQ-022 Rule per cell: count the 8 neighbours; the cell is alive next if count==3, or if alive and count==2.
REQ-023 Column neighbours: with wrap, column 0 and column 7 are adjacent; without wrap, columns outside 0..7 are dead.
REQ-024 On the r==31 cycle: the FSM enters IDLE and gen_count increments, wrapping modulo 2^16.
REQ-025 busy is high exactly in PREP and COMP: 33 cycles per generation, starting the cycle after step is accepted.
REQ-026 step while busy is ignored and not queued.
REQ-027 en=0 freezes the FSM, r, prev, first and the grid; loads and steps are ignored; rd_cells stays live.
REQ-028 During COMP, rd_cells may show a mix of old and new rows; this is defined behaviour.

Reset
REQ-029 When rst_n=0 on an edge, regardless of en: grid all 0, FSM IDLE, r=0, prev=0, first=0, busy=0, gen_count=0, wr_drop=0.
REQ-030 Reset during COMP aborts the generation; no partial gen_count increment occurs.

Configuration
REQ-031 Macro SILIFE_WRAP_EN defined: toroidal grid, rows 0/31 and columns 0/7 are neighbours.
REQ-032 Macro SILIFE_WRAP_EN undefined: dead boundary on all edges; first is unused and may be optimised away.

Structure
REQ-033 Package silife_pkg holds SILIFE_ROWS=32, SILIFE_COLS=8 and the FSM state enum (IDLE, PREP, COMP).
REQ-034 Sub-module silife_rule: a combinational block mapping (prev,cur,next,8b each) to the next row; it honours SILIFE_WRAP_EN for columns.

Verification
REQ-035 Blinker: load rows 10,11,12 = 8'h04 and all others 0, then step. Required: busy high 33 cycles; afterwards row10=0, row11=8'h0E, row12=0; gen_count=1.
REQ-036 Block still life: rows 5,6 = 8'h18, then 3 steps. Required: grid unchanged; gen_count=3.
REQ-037 Wrap, with SILIFE_WRAP_EN: rows 31,0,1 = 8'h80 (vertical blinker at column 7 across the row seam), step. Required: row0 = 8'h C1, rows 31 and 1 = 0. Without the macro: all rows 0 after 1 step.
REQ-038 Load during busy: wr_en=1, row_select=3, cells=8'hFF on the 5th busy cycle. Required: grid[3] unchanged; wr_drop=1 until reset.
REQ-039 Reset mid-COMP: rst_n=0 on the 20th busy cycle. Required: next cycle grid=0, busy=0, gen_count=0.
REQ-040 en gating: en=0 for 10 cycles in the middle of COMP. Required: busy stays high; total busy cycles = 43; result identical to the un-gated run.

Source files
------------

// File: rtl/silife_pkg.sv
// silife_pkg -- shared constants and types for the SILIFE evolver.
//   SILIFE_ROWS : grid height (rows), fixed at 32
//   SILIFE_COLS : grid width (cells per row), fixed at 8
//   state_t     : generation FSM states
// Optional feature macro used by the design files: SILIFE_WRAP_EN.
package silife_pkg;

  localparam int SILIFE_ROWS = 32;
  localparam int SILIFE_COLS = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    COMP = 2'd2
  } state_t;

endpackage

// File: rtl/silife_evolver_if.sv
// silife_evolver_if -- pattern-source / readout bus of the evolver.
//   en, wr_en, row_select, cells, step, rd_row : driven by the master
//   rd_cells, busy, gen_count, wr_drop         : driven by the evolver (slave)
interface silife_evolver_if;
  import silife_pkg::*;

  logic                   en;
  logic                   wr_en;
  logic [4:0]             row_select;
  logic [SILIFE_COLS-1:0] cells;
  logic                   step;
  logic [4:0]             rd_row;
  logic [SILIFE_COLS-1:0] rd_cells;
  logic                   busy;
  logic [15:0]            gen_count;
  logic                   wr_drop;

  modport master (
    output en, wr_en, row_select, cells, step, rd_row,
    input  rd_cells, busy, gen_count, wr_drop
  );

  modport slave (
    input  en, wr_en, row_select, cells, step, rd_row,
    output rd_cells, busy, gen_count, wr_drop
  );

endinterface

// File: rtl/silife_rule.sv
// silife_rule -- combinational Life rule for one 8-cell row.
//   prev_i : row above the row being updated
//   cur_i  : row being updated
//   next_i : row below the row being updated
//   row_o  : next-generation value of cur_i
// SILIFE_WRAP_EN defined: columns 0 and 7 are neighbours; otherwise the
// columns outside 0..7 read as dead.
module silife_rule
  import silife_pkg::*;
(
  input  logic [SILIFE_COLS-1:0] prev_i,
  input  logic [SILIFE_COLS-1:0] cur_i,
  input  logic [SILIFE_COLS-1:0] next_i,
  output logic [SILIFE_COLS-1:0] row_o
);

  // Pad a row with one guard column on each side: bit 0 is column -1,
  // bit 9 is column 8, bit c+1 is column c.
  function automatic logic [SILIFE_COLS+1:0] extend(input logic [SILIFE_COLS-1:0] row);
`ifdef SILIFE_WRAP_EN
    extend = {row[0], row, row[SILIFE_COLS-1]};
`else
    extend = {1'b0, row, 1'b0};
`endif
  endfunction

  // Number of live neighbours of column col, using padded rows.
  function automatic logic [3:0] nb_count(input logic [SILIFE_COLS+1:0] p,
                                          input logic [SILIFE_COLS+1:0] c,
                                          input logic [SILIFE_COLS+1:0] n,
                                          input int col);
    nb_count = {3'b000, p[col]} + {3'b000, p[col+1]} + {3'b000, p[col+2]}
             + {3'b000, c[col]}                      + {3'b000, c[col+2]}
             + {3'b000, n[col]} + {3'b000, n[col+1]} + {3'b000, n[col+2]};
  endfunction

  logic [SILIFE_COLS+1:0] prev_x_s;
  logic [SILIFE_COLS+1:0] cur_x_s;
  logic [SILIFE_COLS+1:0] next_x_s;

  assign prev_x_s = extend(prev_i);
  assign cur_x_s  = extend(cur_i);
  assign next_x_s = extend(next_i);

  // Birth on exactly 3 neighbours, survival on 2 or 3.
  always_comb begin
    row_o = {SILIFE_COLS{1'b0}};
    for (int col = 0; col < SILIFE_COLS; col++) begin
      row_o[col] = (nb_count(prev_x_s, cur_x_s, next_x_s, col) == 4'd3) ||
                   (cur_i[col] && (nb_count(prev_x_s, cur_x_s, next_x_s, col) == 4'd2));
    end
  end

endmodule

// File: rtl/silife_evolver.sv
// silife_evolver -- 32x8 Game of Life grid with row loader and in-place
// row-serial generation engine (one row per cycle).
//   clk   : clock, all state changes on the rising edge
//   rst_n : synchronous active-low reset (dominates en)
//   bus   : silife_evolver_if.slave -- load/step/readout handshake
// SILIFE_WRAP_EN defined: toroidal grid (rows 0/31 and columns 0/7 adjacent);
// undefined: dead boundary on all edges.
module silife_evolver
  import silife_pkg::*;
#(
  parameter int ROWS = SILIFE_ROWS,
  parameter int COLS = SILIFE_COLS
) (
  input  logic            clk,
  input  logic            rst_n,
  silife_evolver_if.slave bus
);

  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

  state_t            state_q;
  logic [COLS-1:0]   grid_q [ROWS];
  logic [4:0]        r_q;
  logic [COLS-1:0]   prev_q;
`ifdef SILIFE_WRAP_EN
  logic [COLS-1:0]   first_q;
`endif
  logic              busy_q;
  logic              wr_drop_q;
  logic [15:0]       gen_count_q;

  logic [COLS-1:0]   cur_s;
  logic [COLS-1:0]   next_s;
  logic [COLS-1:0]   new_row_s;

  // Rows feeding the rule. The row below the last row is the original row 0
  // (latched before row 0 was overwritten), or dead without wrap.
  always_comb begin
    cur_s = grid_q[r_q];
    if (r_q == LAST_ROW) begin
`ifdef SILIFE_WRAP_EN
      next_s = first_q;
`else
      next_s = {COLS{1'b0}};
`endif
    end else begin
      next_s = grid_q[r_q + 5'd1];
    end
  end

  silife_rule u_rule (
    .prev_i (prev_q),
    .cur_i  (cur_s),
    .next_i (next_s),
    .row_o  (new_row_s)
  );

  // Generation FSM, grid storage, loader and status flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      r_q         <= 5'd0;
      prev_q      <= {COLS{1'b0}};
`ifdef SILIFE_WRAP_EN
      first_q     <= {COLS{1'b0}};
`endif
      gen_count_q <= 16'd0;
      wr_drop_q   <= 1'b0;
      for (int i = 0; i < ROWS; i++) begin
        grid_q[i] <= {COLS{1'b0}};
      end
    end else if (bus.en) begin
      // Loads only land while idle; a load during a generation is flagged.
      if (bus.wr_en) begin
        if (busy_q) begin
          wr_drop_q <= 1'b1;
        end else begin
          grid_q[bus.row_select] <= bus.cells;
        end
      end

      case (state_q)
        IDLE: begin
          // A simultaneous load wins; the step is discarded.
          if (bus.step && !bus.wr_en) begin
            state_q <= PREP;
            busy_q  <= 1'b1;
          end
        end
        PREP: begin
`ifdef SILIFE_WRAP_EN
          first_q <= grid_q[0];
          prev_q  <= grid_q[ROWS-1];
`else
          prev_q  <= {COLS{1'b0}};
`endif
          r_q     <= 5'd0;
          state_q <= COMP;
        end
        COMP: begin
          // In-place update is safe: prev_q keeps the old copy of the row above.
          grid_q[r_q] <= new_row_s;
          prev_q      <= cur_s;
          r_q         <= r_q + 5'd1;
          if (r_q == LAST_ROW) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            gen_count_q <= gen_count_q + 16'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rd_cells  = grid_q[bus.rd_row];
  assign bus.busy      = busy_q;
  assign bus.gen_count = gen_count_q;
  assign bus.wr_drop   = wr_drop_q;

endmodule

// File: tb/tb_silife_evolver.sv
// tb_silife_evolver -- directed bench for silife_evolver: a table of
// single-generation rule vectors plus hand-written multi-cycle sequences.
module tb_silife_evolver;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_miss;

  silife_evolver_if bus ();

  silife_evolver dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] in_row  [3];   // rows 10..12 before the step
    logic [7:0] exp_row [5];   // rows 9..13 after one step
  } rule_vec_t;

  rule_vec_t  vecs [6];
  logic [7:0] exp_grid [32];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic load(input logic [4:0] row, input logic [7:0] data);
    bus.wr_en      = 1'b1;
    bus.row_select = row;
    bus.cells      = data;
    tick();
    bus.wr_en      = 1'b0;
  endtask

  task automatic clear_exp();
    for (int r = 0; r < 32; r++) exp_grid[r] = 8'h00;
  endtask

  task automatic check_grid(input string tag);
    for (int r = 0; r < 32; r++) begin
      bus.rd_row = 5'(r);
      @(negedge clk);
      chk($sformatf("%s row%0d", tag, r), {8'h00, bus.rd_cells}, {8'h00, exp_grid[r]});
    end
  endtask

  // Issue a step and count the busy cycles that follow (bounded).
  task automatic run_step(output int nbusy);
    bus.step = 1'b1;
    tick();
    bus.step = 1'b0;
    nbusy = 0;
    while (bus.busy && nbusy < 200) begin
      nbusy++;
      tick();
    end
  endtask

  task automatic load_blinker();
    load(5'd10, 8'h04);
    load(5'd11, 8'h04);
    load(5'd12, 8'h04);
  endtask

  task automatic exp_blinker_result();
    clear_exp();
    exp_grid[11] = 8'h0E;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    n_vec  = 0;
    n_miss = 0;
    rst_n          = 1'b0;
    bus.en         = 1'b1;
    bus.wr_en      = 1'b0;
    bus.row_select = 5'd0;
    bus.cells      = 8'h00;
    bus.step       = 1'b0;
    bus.rd_row     = 5'd0;

    vecs[0].in_row = '{8'h04, 8'h04, 8'h04};
    vecs[0].exp_row = '{8'h00, 8'h00, 8'h0E, 8'h00, 8'h00};
    vecs[1].in_row = '{8'h00, 8'h0E, 8'h00};
    vecs[1].exp_row = '{8'h00, 8'h04, 8'h04, 8'h04, 8'h00};
    vecs[2].in_row = '{8'h00, 8'h18, 8'h18};
    vecs[2].exp_row = '{8'h00, 8'h00, 8'h18, 8'h18, 8'h00};
    vecs[3].in_row = '{8'h00, 8'h08, 8'h00};
    vecs[3].exp_row = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[4].in_row = '{8'h02, 8'h04, 8'h08};
    vecs[4].exp_row = '{8'h00, 8'h00, 8'h04, 8'h00, 8'h00};
    vecs[5].in_row = '{8'h00, 8'h7E, 8'h00};
    vecs[5].exp_row = '{8'h00, 8'h3C, 8'h3C, 8'h3C, 8'h00};

    // Reset state
    tick();
    tick();
    rst_n = 1'b1;
    chk("reset busy", {15'd0, bus.busy}, 16'd0);
    chk("reset gen_count", bus.gen_count, 16'd0);
    chk("reset wr_drop", {15'd0, bus.wr_drop}, 16'd0);
    clear_exp();
    check_grid("reset");

    // Table of single-generation rule vectors on rows 10..12
    for (int i = 0; i < 6; i++) begin
      do_reset();
      for (int k = 0; k < 3; k++) load(5'(10 + k), vecs[i].in_row[k]);
      run_step(n);
      chk($sformatf("vec%0d busy cycles", i), 16'(n), 16'd33);
      chk($sformatf("vec%0d gen_count", i), bus.gen_count, 16'd1);
      clear_exp();
      for (int k = 0; k < 5; k++) exp_grid[9 + k] = vecs[i].exp_row[k];
      check_grid($sformatf("vec%0d", i));
    end

    // Block still life over three generations
    do_reset();
    load(5'd5, 8'h18);
    load(5'd6, 8'h18);
    for (int s = 0; s < 3; s++) begin
      run_step(n);
      chk($sformatf("block step%0d busy cycles", s), 16'(n), 16'd33);
    end
    chk("block gen_count", bus.gen_count, 16'd3);
    clear_exp();
    exp_grid[5] = 8'h18;
    exp_grid[6] = 8'h18;
    check_grid("block");

    // Vertical blinker at column 7 across the row seam
    do_reset();
    load(5'd31, 8'h80);
    load(5'd0, 8'h80);
    load(5'd1, 8'h80);
    run_step(n);
    chk("seam busy cycles", 16'(n), 16'd33);
    clear_exp();
`ifdef SILIFE_WRAP_EN
    exp_grid[0] = 8'hC1;
`endif
    check_grid("seam");

    // Step and load on the same edge: load wins, step discarded
    do_reset();
    bus.wr_en      = 1'b1;
    bus.row_select = 5'd7;
    bus.cells      = 8'h3C;
    bus.step       = 1'b1;
    tick();
    bus.wr_en = 1'b0;
    bus.step  = 1'b0;
    chk("load+step busy", {15'd0, bus.busy}, 16'd0);
    tick();
    chk("load+step busy later", {15'd0, bus.busy}, 16'd0);
    bus.rd_row = 5'd7;
    @(negedge clk);
    chk("load+step row7", {8'h00, bus.rd_cells}, 16'h003C);
    chk("load+step gen_count", bus.gen_count, 16'd0);

    // Step while busy is ignored and not queued
    do_reset();
    load_blinker();
    bus.step = 1'b1;
    tick();
    n = 0;
    while (bus.busy && n < 200) begin
      n++;
      bus.step = (n == 10);
      tick();
    end
    bus.step = 1'b0;
    chk("busy step busy cycles", 16'(n), 16'd33);
    tick();
    chk("busy step not queued", {15'd0, bus.busy}, 16'd0);
    chk("busy step gen_count", bus.gen_count, 16'd1);

    // Load on the 5th busy cycle is dropped and flagged
    do_reset();
    load_blinker();
    bus.step = 1'b1;
    tick();
    bus.step = 1'b0;
    bus.row_select = 5'd3;
    bus.cells      = 8'hFF;
    n = 0;
    while (bus.busy && n < 200) begin
      n++;
      bus.wr_en = (n == 5);
      tick();
    end
    bus.wr_en = 1'b0;
    chk("drop busy cycles", 16'(n), 16'd33);
    chk("drop wr_drop set", {15'd0, bus.wr_drop}, 16'd1);
    exp_blinker_result();
    check_grid("drop");
    run_step(n);
    chk("drop wr_drop sticky", {15'd0, bus.wr_drop}, 16'd1);
    do_reset();
    chk("drop wr_drop cleared", {15'd0, bus.wr_drop}, 16'd0);

    // Reset on the 20th busy cycle of a second generation
    do_reset();
    load_blinker();
    run_step(n);
    chk("abort first gen_count", bus.gen_count, 16'd1);
    bus.step = 1'b1;
    tick();
    bus.step = 1'b0;
    n = 0;
    while (bus.busy && n < 20) begin
      n++;
      if (n == 20) rst_n = 1'b0;
      tick();
    end
    rst_n = 1'b1;
    chk("abort reached cycle 20", 16'(n), 16'd20);
    chk("abort busy", {15'd0, bus.busy}, 16'd0);
    chk("abort gen_count", bus.gen_count, 16'd0);
    clear_exp();
    check_grid("abort");
    chk("abort busy later", {15'd0, bus.busy}, 16'd0);

    // en held low for 10 cycles in the middle of COMP
    do_reset();
    load_blinker();
    bus.step = 1'b1;
    tick();
    bus.step = 1'b0;
    n = 0;
    while (bus.busy && n < 200) begin
      n++;
      bus.en = !(n >= 15 && n < 25);
      tick();
    end
    bus.en = 1'b1;
    chk("gated busy cycles", 16'(n), 16'd43);
    chk("gated gen_count", bus.gen_count, 16'd1);
    exp_blinker_result();
    check_grid("gated");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
